// File: rtl/pwm_capture.sv
// PWM period / high-time capture block with a small Wishbone register file.
// Measures the synchronised pwm_in in clk ticks and flags valid captures or timeouts.
module pwm_capture #(
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwm_in,
  input  logic       wb_stb,
  input  logic       wb_we,
  input  logic [2:0] wb_adr,
  input  logic [7:0] wb_dat_i,
  output logic       wb_ack,
  output logic [7:0] wb_dat_o,
  output logic       irq
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_reg, state_next;
  logic             sync1_reg, sync2_reg, sync3_reg;
  logic [CNT_W-1:0] per_cnt_reg, per_cnt_next;
  logic [CNT_W-1:0] hi_cnt_reg, hi_cnt_next;
  logic [CNT_W-1:0] period_reg, period_next;
  logic [CNT_W-1:0] high_reg, high_next;
  logic             valid_reg, valid_next;
  logic             timeout_reg, timeout_next;
  logic [1:0]       ctrl_reg, ctrl_next;
  logic [7:0]       snap_hi_h_reg, snap_per_l_reg, snap_per_h_reg;
  logic [15:0]      period_ext, high_ext;
  logic             rise, fall, enable;
  logic             ctrl_wr, status_rd, high_rd;
  logic             capture, timeout_evt;
  logic             unused_dat;

  assign unused_dat = ^wb_dat_i[7:2];

  assign rise = sync2_reg & ~sync3_reg;
  assign fall = ~sync2_reg & sync3_reg;

  assign ctrl_wr   = wb_stb & wb_we & (wb_adr == 3'd1);
  assign status_rd = wb_stb & ~wb_we & (wb_adr == 3'd0);
  assign high_rd   = wb_stb & ~wb_we & (wb_adr == 3'd2);

  // A write clearing enable aborts the measurement on the same edge it lands.
  assign ctrl_next = ctrl_wr ? wb_dat_i[1:0] : ctrl_reg;
  assign enable    = ctrl_next[0];

  always_comb begin
    state_next   = state_reg;
    per_cnt_next = per_cnt_reg;
    hi_cnt_next  = hi_cnt_reg;
    period_next  = period_reg;
    high_next    = high_reg;
    capture      = 1'b0;
    timeout_evt  = 1'b0;
    if (!enable) begin
      state_next   = IDLE;
      per_cnt_next = '0;
      hi_cnt_next  = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (rise) begin
            state_next   = HIGH;
            per_cnt_next = CNT_ONE;
            hi_cnt_next  = CNT_ONE;
          end
        end
        HIGH: begin
          if (per_cnt_reg == CNT_MAX) begin
            timeout_evt = 1'b1;
          end else if (fall) begin
            state_next   = LOW;
            per_cnt_next = per_cnt_reg + CNT_ONE;
          end else begin
            per_cnt_next = per_cnt_reg + CNT_ONE;
            hi_cnt_next  = hi_cnt_reg + CNT_ONE;
          end
        end
        LOW: begin
          if (per_cnt_reg == CNT_MAX) begin
            timeout_evt = 1'b1;
          end else if (rise) begin
            capture      = 1'b1;
            period_next  = per_cnt_reg;
            high_next    = hi_cnt_reg;
            state_next   = HIGH;
            per_cnt_next = CNT_ONE;
            hi_cnt_next  = CNT_ONE;
          end else begin
            per_cnt_next = per_cnt_reg + CNT_ONE;
          end
        end
        default: state_next = IDLE;
      endcase
      if (timeout_evt) begin
        state_next   = IDLE;
        per_cnt_next = '0;
        hi_cnt_next  = '0;
        period_next  = '0;
        high_next    = '0;
      end
    end
  end

  // Set events win over the clear-on-read of STATUS.
  assign valid_next   = capture | (valid_reg & ~status_rd);
  assign timeout_next = timeout_evt | (timeout_reg & ~status_rd);

  always_comb begin
    period_ext = '0;
    high_ext   = '0;
    period_ext[CNT_W-1:0] = period_reg;
    high_ext[CNT_W-1:0]   = high_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      sync1_reg      <= 1'b0;
      sync2_reg      <= 1'b0;
      sync3_reg      <= 1'b0;
      per_cnt_reg    <= '0;
      hi_cnt_reg     <= '0;
      period_reg     <= '0;
      high_reg       <= '0;
      valid_reg      <= 1'b0;
      timeout_reg    <= 1'b0;
      ctrl_reg       <= 2'b00;
      snap_hi_h_reg  <= 8'h00;
      snap_per_l_reg <= 8'h00;
      snap_per_h_reg <= 8'h00;
    end else begin
      state_reg   <= state_next;
      sync1_reg   <= pwm_in;
      sync2_reg   <= sync1_reg;
      sync3_reg   <= sync2_reg;
      per_cnt_reg <= per_cnt_next;
      hi_cnt_reg  <= hi_cnt_next;
      period_reg  <= period_next;
      high_reg    <= high_next;
      valid_reg   <= valid_next;
      timeout_reg <= timeout_next;
      ctrl_reg    <= ctrl_next;
      // Snapshot takes the pre-capture values, matching the live byte returned.
      if (high_rd) begin
        snap_hi_h_reg  <= high_ext[15:8];
        snap_per_l_reg <= period_ext[7:0];
        snap_per_h_reg <= period_ext[15:8];
      end
    end
  end

  assign wb_ack = wb_stb;

  always_comb begin
    wb_dat_o = 8'h00;
    case (wb_adr)
      3'd0:    wb_dat_o = {4'b0000, (state_reg != IDLE), sync2_reg, timeout_reg, valid_reg};
      3'd1:    wb_dat_o = {6'b000000, ctrl_reg};
      3'd2:    wb_dat_o = high_ext[7:0];
      3'd3:    wb_dat_o = snap_hi_h_reg;
      3'd4:    wb_dat_o = snap_per_l_reg;
      3'd5:    wb_dat_o = snap_per_h_reg;
      default: wb_dat_o = 8'h00;
    endcase
  end

  assign irq = ctrl_reg[1] & (valid_reg | timeout_reg);

endmodule

// File: tb/tb_pwm_capture.sv
// Directed scoreboard bench for pwm_capture: PWM generator plus manual edges,
// Wishbone reads checked against expected values queued when each read is issued.
module tb_pwm_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic       pwm_in;
  logic       wb_stb;
  logic       wb_we;
  logic [2:0] wb_adr;
  logic [7:0] wb_dat_i;
  logic       wb_ack;
  logic [7:0] wb_dat_o;
  logic       irq;

  int    vectors = 0;
  int    miscompares = 0;
  logic [7:0] exp_q[$];
  string      tag_q[$];

  bit pwm_run = 1'b0;
  bit pwm_man = 1'b0;
  int pwm_per = 100;
  int pwm_hi  = 25;
  int ph = 0;

  pwm_capture #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in),
    .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr), .wb_dat_i(wb_dat_i),
    .wb_ack(wb_ack), .wb_dat_o(wb_dat_o), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!pwm_run) ph <= 0;
    else if (ph >= pwm_per - 1) ph <= 0;
    else ph <= ph + 1;
  end

  assign pwm_in = pwm_man | (pwm_run & (ph < pwm_hi));

  task automatic expect_val(input logic [7:0] e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic chk(input logic [7:0] obs);
    logic [7:0] e;
    string t;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty: got 0x%02h required an expected entry", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        miscompares++;
        $error("FAIL %s: got 0x%02h expected 0x%02h", t, obs, e);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wb_wr(input logic [2:0] a, input logic [7:0] d);
    wb_stb = 1'b1; wb_we = 1'b1; wb_adr = a; wb_dat_i = d;
    @(posedge clk); #1;
    wb_stb = 1'b0; wb_we = 1'b0;
    $display("write adr=%0d dat=0x%02h", a, d);
  endtask

  task automatic wb_rd(input logic [2:0] a, input logic [7:0] e, input string tag);
    expect_val(e, tag);
    expect_val(8'h01, {tag, "_ack"});
    wb_stb = 1'b1; wb_we = 1'b0; wb_adr = a;
    @(negedge clk);
    $display("read  adr=%0d dat=0x%02h exp=0x%02h (%s)", a, wb_dat_o, e, tag);
    chk(wb_dat_o);
    chk({7'b0, wb_ack});
    @(posedge clk); #1;
    wb_stb = 1'b0;
  endtask

  task automatic chk_irq(input logic e, input string tag);
    expect_val({7'b0, e}, tag);
    $display("irq   = %0b exp=%0b (%s)", irq, e, tag);
    chk({7'b0, irq});
  endtask

  initial begin
    rst = 1'b1; wb_stb = 1'b0; wb_we = 1'b0; wb_adr = 3'd0; wb_dat_i = 8'h00;
    tick(1);
    // Write during reset must be lost.
    wb_wr(3'd1, 8'h03);
    wb_rd(3'd0, 8'h00, "rst_status");
    rst = 1'b0;
    wb_rd(3'd1, 8'h00, "rst_ctrl");
    wb_rd(3'd2, 8'h00, "rst_high");
    wb_rd(3'd3, 8'h00, "rst_high_h");
    wb_rd(3'd4, 8'h00, "rst_per_l");
    wb_rd(3'd5, 8'h00, "rst_per_h");
    wb_rd(3'd6, 8'h00, "rst_adr6");
    wb_rd(3'd7, 8'h00, "rst_adr7");
    chk_irq(1'b0, "rst_irq");

    // Enable; upper CTRL bits and other addresses ignore writes.
    wb_wr(3'd1, 8'hFD);
    wb_wr(3'd3, 8'hFF);
    wb_rd(3'd1, 8'h01, "ctrl_mask");

    // Period 100, high 25.
    pwm_per = 100; pwm_hi = 25; pwm_run = 1'b1;
    tick(250);
    pwm_run = 1'b0;
    tick(5);
    wb_rd(3'd0, 8'h09, "p100_status");
    wb_rd(3'd0, 8'h08, "p100_status_clr");
    wb_rd(3'd2, 8'd25, "p100_high");
    wb_rd(3'd3, 8'h00, "p100_high_h");
    wb_rd(3'd4, 8'd100, "p100_per_l");
    wb_rd(3'd5, 8'h00, "p100_per_h");

    // Period 1000, high 999.
    pwm_per = 1000; pwm_hi = 999; pwm_run = 1'b1;
    tick(2500);
    pwm_run = 1'b0;
    tick(5);
    wb_rd(3'd2, 8'hE7, "p1000_high");
    wb_rd(3'd3, 8'h03, "p1000_high_h");
    wb_rd(3'd4, 8'hE8, "p1000_per_l");
    wb_rd(3'd5, 8'h03, "p1000_per_h");

    // Later captures must not disturb the snapshot until the next addr-2 read.
    pwm_per = 300; pwm_hi = 100; pwm_run = 1'b1;
    tick(700);
    pwm_run = 1'b0;
    tick(5);
    wb_rd(3'd3, 8'h03, "snap_hold_high_h");
    wb_rd(3'd4, 8'hE8, "snap_hold_per_l");
    wb_rd(3'd5, 8'h03, "snap_hold_per_h");
    wb_rd(3'd2, 8'h64, "p300_high");
    wb_rd(3'd3, 8'h00, "p300_high_h");
    wb_rd(3'd4, 8'h2C, "p300_per_l");
    wb_rd(3'd5, 8'h01, "p300_per_h");

    // Interrupt behaviour.
    wb_wr(3'd1, 8'h03);
    chk_irq(1'b1, "irq_pending");
    wb_rd(3'd0, 8'h09, "irq_status");
    chk_irq(1'b0, "irq_cleared");
    pwm_per = 100; pwm_hi = 25; pwm_run = 1'b1;
    tick(250);
    pwm_run = 1'b0;
    tick(5);
    chk_irq(1'b1, "irq_capture");
    wb_rd(3'd0, 8'h09, "irq_status2");
    chk_irq(1'b0, "irq_cleared2");

    // Hand-placed edges: capture coincident with STATUS read, then with addr-2 read.
    pwm_man = 1'b1;
    tick(2);
    wb_rd(3'd0, 8'h0C, "coinc_status_old");
    chk_irq(1'b1, "coinc_irq");
    wb_rd(3'd0, 8'h0D, "coinc_valid_kept");
    chk_irq(1'b0, "coinc_irq_clr");
    pwm_man = 1'b0;
    tick(6);
    pwm_man = 1'b1;
    tick(5);
    pwm_man = 1'b0;
    tick(7);
    pwm_man = 1'b1;
    tick(2);
    wb_rd(3'd2, 8'd4, "coinc_high_old");
    wb_rd(3'd3, 8'h00, "coinc_high_h");
    wb_rd(3'd4, 8'd10, "coinc_per_old");
    wb_rd(3'd5, 8'h00, "coinc_per_h");
    wb_rd(3'd2, 8'd5, "coinc_high_new");
    wb_rd(3'd4, 8'd12, "coinc_per_new");

    // Abort mid-HIGH by clearing enable.
    wb_rd(3'd0, 8'h0D, "abort_pre");
    wb_wr(3'd1, 8'h02);
    wb_rd(3'd0, 8'h04, "abort_busy0");
    wb_rd(3'd2, 8'd5, "abort_high_kept");
    wb_rd(3'd4, 8'd12, "abort_per_kept");

    // Stuck-high timeout, then recovery.
    pwm_man = 1'b0;
    tick(5);
    wb_wr(3'd1, 8'h01);
    pwm_man = 1'b1;
    tick(70000);
    wb_rd(3'd0, 8'h06, "timeout_status");
    wb_rd(3'd2, 8'h00, "timeout_high");
    wb_rd(3'd3, 8'h00, "timeout_high_h");
    wb_rd(3'd4, 8'h00, "timeout_per_l");
    wb_rd(3'd5, 8'h00, "timeout_per_h");
    pwm_man = 1'b0;
    tick(10);
    pwm_man = 1'b1;
    tick(20);
    pwm_man = 1'b0;
    tick(30);
    pwm_man = 1'b1;
    tick(5);
    wb_rd(3'd2, 8'd20, "recover_high");
    wb_rd(3'd4, 8'd50, "recover_per_l");
    wb_rd(3'd3, 8'h00, "recover_high_h");
    wb_rd(3'd5, 8'h00, "recover_per_h");
    wb_rd(3'd0, 8'h0D, "recover_status");

    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_leftover: got %0d entries required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter CNT_W, default 16, counter/measurement width in clk ticks, legal range 9..16.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port pwm_in  input  1  external PWM signal, asynchronous to clk.
REQ-005 SHALL have port wb_stb  input  1  Wishbone strobe (cycle+strobe combined).
REQ-006 SHALL have port wb_we  input  1  Wishbone write enable.
REQ-007 SHALL have port wb_adr  input  3  register address.
REQ-008 SHALL have port wb_dat_i  input  8  write data.
REQ-009 SHALL have port wb_ack  output  1  Wishbone acknowledge.
REQ-010 SHALL have port wb_dat_o  output  8  read data.
REQ-011 SHALL have port irq  output  1  level interrupt request.

Function
REQ-012 SHALL pass pwm_in through a 2-flop synchronizer, then a third flop for edge detection; edges are acted on 3 clk cycles after the pwm_in transition.
REQ-013 SHALL implement states IDLE, HIGH, LOW; IDLE -> HIGH on synced rising edge while enabled; HIGH -> LOW on synced falling edge; LOW -> HIGH on synced rising edge.
REQ-014 SHALL, on each rising edge from IDLE, load period counter and high counter with 1, without capture.
REQ-015 SHALL, in HIGH and LOW, increment period counter each cycle; SHALL increment high counter only in HIGH.
REQ-016 SHALL, on a rising edge in LOW, copy period counter to PERIOD and high counter to HIGH, set status valid, then reload both counters with 1 (so period of P cycles, high time H cycles read as P and H).
REQ-017 SHALL, when period counter reaches 2^CNT_W-1 in HIGH or LOW, set PERIOD=0, HIGH=0, set status timeout, go to IDLE (covers stuck-high and stuck-low inputs).
REQ-018 SHALL hold state IDLE and counters at 0 while CTRL.enable=0; clearing enable mid-measurement aborts it with no capture; PERIOD/HIGH keep last values.
REQ-019 SHALL assert wb_ack combinationally equal to wb_stb (zero wait states) and drive wb_dat_o combinationally from wb_adr.
REQ-020 SHALL map registers: 0 STATUS (RO: bit0 valid, bit1 timeout, bit2 synced level, bit3 busy = state!=IDLE), 1 CTRL (RW: bit0 enable, bit1 irq_en), 2 HIGH[7:0], 3 HIGH_H snapshot, 4 PERIOD_L snapshot, 5 PERIOD_H snapshot, 6-7 read 0.
REQ-021 SHALL, on a read of address 2, return live HIGH[7:0] and load snapshot registers with HIGH[15:8], PERIOD[7:0], PERIOD[15:8] of the same cycle, giving a coherent 16-bit pair.
REQ-022 SHALL zero-extend values when CNT_W<16 (unused upper bits read 0).
REQ-023 SHALL clear valid and timeout on a STATUS read; a set event in the same cycle SHALL win (bit reads old value, remains 1 after).
REQ-024 SHALL, when a capture coincides with an address-2 read, return and snapshot the pre-capture values.
REQ-025 SHALL ignore writes to addresses other than 1; CTRL bits 7:2 read 0.
REQ-026 SHALL drive irq = CTRL.irq_en & (valid | timeout), registered-free (combinational from flops).

Reset
REQ-027 SHALL, with rst high at a clk edge, set state IDLE, counters 0, PERIOD 0, HIGH 0, snapshots 0, STATUS bits 0, CTRL 0x00, synchronizer flops 0; irq=0, wb_dat_o reflects reset registers, wb_ack still follows wb_stb.
REQ-028 SHALL take rst priority over all other events including Wishbone writes in the same cycle.

Verification
REQ-029 Enable, pwm_in period 100 cycles high 25 -> after second rising edge STATUS=0x0D-ish valid, addr2 read 25 then addr3 0, addr4 100, addr5 0.
REQ-030 Period 1000 high 999 -> HIGH=999 (0x03E7), PERIOD=1000 (0x03E8) via addr2/3/4/5 sequence; addr3 snapshot unchanged by later captures until next addr2 read.
REQ-031 pwm_in held high 70000 cycles, CNT_W=16 -> timeout=1, PERIOD=0, HIGH=0, state IDLE; next valid waveform recovers after two rising edges.
REQ-032 CTRL.irq_en=1, valid capture -> irq=1; STATUS read -> irq=0 next cycle; capture coincident with STATUS read -> valid stays 1.
REQ-033 Clear enable mid-HIGH -> busy=0 next cycle, PERIOD/HIGH unchanged; rst asserted with wb write 0x03 to CTRL -> CTRL reads 0x00.
